// File: rtl/padslice_sync_filter.sv
// padslice_sync_filter: registered pad-slice front-end.
// Input path per channel: ie gating, synchroniser, debounce, edge detect, sticky interrupts.
// Output path: out/oe registered once before the pad slice.
module padslice_sync_filter #(
    parameter int unsigned Width      = 8,
    parameter int unsigned CntWidth   = 4,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    pad_in_i,
    input  logic [Width-1:0]    ie_i,
    input  logic [Width-1:0]    filt_en_i,
    input  logic [CntWidth-1:0] filt_thresh_i,
    input  logic [Width-1:0]    out_i,
    input  logic [Width-1:0]    oe_i,
    output logic [Width-1:0]    pad_out_o,
    output logic [Width-1:0]    pad_oe_o,
    output logic [Width-1:0]    data_o,
    output logic [Width-1:0]    rise_o,
    output logic [Width-1:0]    fall_o,
    input  logic [Width-1:0]    intr_en_rise_i,
    input  logic [Width-1:0]    intr_en_fall_i,
    input  logic [Width-1:0]    intr_clr_i,
    output logic [Width-1:0]    intr_state_o,
    output logic                intr_o
);

    logic [SyncStages-1:0][Width-1:0] sync_r;
    logic [Width-1:0]                 sync_q;
    logic [Width-1:0]                 data_q;
    logic [Width-1:0]                 data_next;
    logic [Width-1:0]                 data_dly_q;
    logic [Width-1:0][CntWidth-1:0]   cnt_q;
    logic [Width-1:0][CntWidth-1:0]   cnt_next;
    logic [Width-1:0]                 intr_q;
    logic [Width-1:0]                 intr_next;
    logic [Width-1:0]                 intr_set;
    logic [CntWidth-1:0]              thr_en;
    logic [CntWidth-1:0]              thr_en_m1;
    logic [CntWidth-1:0]              thr_m1;

    assign sync_q = sync_r[SyncStages-1];

    // Synchroniser shift register fed by the ie-gated pad value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SyncStages-2:0], pad_in_i & ie_i};
        end
    end

    // Threshold clamped to at least one cycle; the comparison uses threshold-1.
    always_comb begin
        thr_en    = (filt_thresh_i == '0) ? CntWidth'(1) : filt_thresh_i;
        thr_en_m1 = thr_en - CntWidth'(1);
    end

    // Debounce next-state: a mismatch must persist eff_thr cycles before data follows.
    always_comb begin
        data_next = data_q;
        cnt_next  = cnt_q;
        thr_m1    = '0;
        for (int i = 0; i < int'(Width); i++) begin
            thr_m1 = filt_en_i[i] ? thr_en_m1 : '0;
            if (sync_q[i] == data_q[i]) begin
                cnt_next[i] = '0;
            end else if (cnt_q[i] >= thr_m1) begin
                data_next[i] = sync_q[i];
                cnt_next[i]  = '0;
            end else if (cnt_q[i] != '1) begin
                cnt_next[i] = cnt_q[i] + CntWidth'(1);
            end
        end
    end

    // Edge pulses come straight from two registered copies of the filtered value.
    assign rise_o = data_q & ~data_dly_q;
    assign fall_o = ~data_q & data_dly_q;

    // Sticky interrupt update; a new event beats a same-cycle clear.
    always_comb begin
        intr_set  = (rise_o & intr_en_rise_i) | (fall_o & intr_en_fall_i);
        intr_next = (intr_q & ~intr_clr_i) | intr_set;
    end

    // Filter, edge-delay and interrupt state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q     <= '0;
            data_dly_q <= '0;
            cnt_q      <= '0;
            intr_q     <= '0;
        end else begin
            data_q     <= data_next;
            data_dly_q <= data_q;
            cnt_q      <= cnt_next;
            intr_q     <= intr_next;
        end
    end

    // Output path registers, independent of the input path.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pad_out_o <= '0;
            pad_oe_o  <= '0;
        end else begin
            pad_out_o <= out_i;
            pad_oe_o  <= oe_i;
        end
    end

    assign data_o       = data_q;
    assign intr_state_o = intr_q;
    assign intr_o       = |intr_q;

endmodule
